// File: rtl/adc_spi_sampler.sv
// Sample-rate timer plus MCP3002-style SPI reader: one 10-bit conversion per
// sample period, presented as offset-binary data_out with a data_valid pulse.
module adc_spi_sampler #(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned SAMPLE_DIV = 5000,
    parameter int unsigned CHANNEL    = 0
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       adc_dout,
    output logic       adc_cs,
    output logic       adc_sck,
    output logic       adc_din,
    output logic [9:0] data_out,
    output logic       data_valid,
    output logic       overrun
);

    localparam int unsigned DATA_W    = 10;
    localparam int unsigned DIV_W     = $clog2(CLK_DIV + 1);
    localparam int unsigned TMR_W     = $clog2(SAMPLE_DIV + 1);
    localparam int unsigned HALF_W    = 6;
    localparam int unsigned EDGE_W    = 5;
    localparam int unsigned LAST_HALF = 32;
    localparam logic        CH_BIT    = (CHANNEL != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [TMR_W-1:0]    timer;
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [HALF_W-1:0]   half_cnt, half_n, half_inc;
    logic [EDGE_W-1:0]   edge_idx;
    logic [DATA_W-1:0]   shreg, shreg_n, data_out_n;
    logic                cs_n, sck_n, din_n, valid_n, overrun_n;
    logic                tick, div_end;

    assign tick     = (timer == TMR_W'(SAMPLE_DIV - 1));
    assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign half_inc = half_cnt + HALF_W'(1);
    // SCK edge number entered by half_inc: odd halves are rising, even falling.
    assign edge_idx = half_inc[5:1] + EDGE_W'(half_inc[0]);

    // Free-running sample timer; unaffected by the frame state.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            half_cnt   <= '0;
            adc_cs     <= 1'b1;
            adc_sck    <= 1'b0;
            adc_din    <= 1'b0;
            shreg      <= '0;
            data_out   <= DATA_W'(512);
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            half_cnt   <= half_n;
            adc_cs     <= cs_n;
            adc_sck    <= sck_n;
            adc_din    <= din_n;
            shreg      <= shreg_n;
            data_out   <= data_out_n;
            data_valid <= valid_n;
            overrun    <= overrun_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = div_cnt;
        half_n     = half_cnt;
        cs_n       = adc_cs;
        sck_n      = adc_sck;
        din_n      = adc_din;
        shreg_n    = shreg;
        data_out_n = data_out;
        valid_n    = 1'b0;
        overrun_n  = overrun;

        if (tick && (state != IDLE)) begin
            overrun_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = SETUP;
                    cs_n    = 1'b0;
                    din_n   = 1'b1;
                    div_n   = '0;
                    half_n  = '0;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    half_n  = HALF_W'(1);
                    sck_n   = 1'b1;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_n = div_cnt + DIV_W'(1);
                end else if (half_cnt == HALF_W'(LAST_HALF)) begin
                    // Tail half-period after the 16th falling edge closes the frame.
                    state_n    = DONE;
                    div_n      = '0;
                    cs_n       = 1'b1;
                    din_n      = 1'b0;
                    data_out_n = shreg;
                    valid_n    = 1'b1;
                end else begin
                    div_n  = '0;
                    half_n = half_inc;
                    sck_n  = half_inc[0];
                    if (half_inc[0]) begin
                        if ((edge_idx >= EDGE_W'(6)) && (edge_idx <= EDGE_W'(15))) begin
                            shreg_n = {shreg[DATA_W-2:0], adc_dout};
                        end
                    end else begin
                        case (edge_idx)
                            EDGE_W'(1): din_n = 1'b1;
                            EDGE_W'(2): din_n = CH_BIT;
                            EDGE_W'(3): din_n = 1'b1;
                            default:    din_n = 1'b0;
                        endcase
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: two instances (CHANNEL 0 / 1) driven by a
// behavioural MCP3002 model, checked against timing computed from the frame rules.
module tb_adc_spi_sampler;

    localparam int unsigned CD  = 2;
    localparam int unsigned SD0 = 100;
    localparam int unsigned SD1 = 60;
    localparam int unsigned LAT = 33 * CD + 1;

    logic       clk = 1'b0;
    logic [1:0] rstn, cs, sck, din, dout, valid, ovr;
    logic [9:0] dat0, dat1;
    logic [9:0] val [2];

    int checks = 0;
    int errors = 0;

    // ADC model state, one slot per instance
    int          rc [2], fc [2], lowcyc [2], stray [2], last_rc [2], last_low [2];
    logic [15:0] dseen [2], last_dseen [2];
    logic        prev_sck [2], was_low [2];

    always #5 clk = ~clk;

    adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_DIV(SD0), .CHANNEL(0)) u0 (
        .sysclk(clk), .rst_n(rstn[0]), .adc_dout(dout[0]), .adc_cs(cs[0]),
        .adc_sck(sck[0]), .adc_din(din[0]), .data_out(dat0),
        .data_valid(valid[0]), .overrun(ovr[0])
    );

    adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_DIV(SD1), .CHANNEL(1)) u1 (
        .sysclk(clk), .rst_n(rstn[1]), .adc_dout(dout[1]), .adc_cs(cs[1]),
        .adc_sck(sck[1]), .adc_din(din[1]), .data_out(dat1),
        .data_valid(valid[1]), .overrun(ovr[1])
    );

    // MCP3002 behaviour: null bit after falling edge 4, then D9..D0 on falls 5..14.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!cs[g]) begin
                if (!was_low[g]) begin
                    rc[g] = 0; fc[g] = 0; dseen[g] = '0; lowcyc[g] = 0;
                end
                lowcyc[g]++;
                if (sck[g] && !prev_sck[g]) begin
                    rc[g]++;
                    if (rc[g] <= 16) dseen[g][rc[g]-1] = din[g];
                end
                if (!sck[g] && prev_sck[g]) begin
                    fc[g]++;
                    dout[g] = (fc[g] >= 5 && fc[g] <= 14) ? val[g][14-fc[g]] : 1'b0;
                end
            end else begin
                if (was_low[g]) begin
                    last_rc[g] = rc[g]; last_low[g] = lowcyc[g]; last_dseen[g] = dseen[g];
                end
                if (sck[g] !== prev_sck[g]) stray[g]++;
                dout[g] = 1'b0;
            end
            was_low[g]  = !cs[g];
            prev_sck[g] = sck[g];
        end
    end

    function automatic logic [15:0] cmd_pattern(input logic ch);
        logic [15:0] p;
        p = '0;
        p[0] = 1'b1; p[1] = 1'b1; p[2] = ch; p[3] = 1'b1;
        return p;
    endfunction

    task automatic test_reset();
        int k;
        val[0] = 10'h2A5;
        repeat ($urandom_range(20, 180)) @(negedge clk);
        #($urandom_range(1, 4));
        rstn[0] = 1'b0;
        #1;
        checks++; if (cs[0] !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", cs[0]); end
        checks++; if (sck[0] !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck[0]); end
        checks++; if (din[0] !== 1'b0) begin errors++; $display("FAIL reset_din got %b want 0", din[0]); end
        checks++; if (dat0 !== 10'd512) begin errors++; $display("FAIL reset_data got %0d want 512", dat0); end
        checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid[0]); end
        checks++; if (ovr[0] !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", ovr[0]); end
        repeat (2) @(negedge clk);
        rstn[0] = 1'b1;
        k = 0;
        while (k < 300 && cs[0] !== 1'b0) begin
            @(posedge clk); #1; k++;
        end
        checks++; if (k !== SD0) begin errors++; $display("FAIL first_cs_fall got %0d want %0d", k, SD0); end
    endtask

    task automatic test_conversion();
        int n, m, held_bad;
        n = 1;
        while (n < 300 && valid[0] !== 1'b1) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (n !== LAT) begin errors++; $display("FAIL conv_latency got %0d want %0d", n, LAT); end
        checks++; if (dat0 !== 10'h2A5) begin errors++; $display("FAIL conv_data got %h want 2a5", dat0); end
        val[0] = 10'h000;
        @(posedge clk); #1;
        checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL conv_pulse_width got %b want 0", valid[0]); end
        checks++; if (last_rc[0] !== 16) begin errors++; $display("FAIL conv_rise_count got %0d want 16", last_rc[0]); end
        checks++; if (last_low[0] !== 33 * CD) begin errors++; $display("FAIL conv_cs_low got %0d want %0d", last_low[0], 33 * CD); end
        m = 1; held_bad = 0;
        while (m < 300 && valid[0] !== 1'b1) begin
            if (dat0 !== 10'h2A5) held_bad++;
            @(posedge clk); #1; m++;
        end
        checks++; if (held_bad !== 0) begin errors++; $display("FAIL conv_hold got %0d changes want 0", held_bad); end
        checks++; if (m !== SD0) begin errors++; $display("FAIL conv_period got %0d want %0d", m, SD0); end
        checks++; if (dat0 !== 10'h000) begin errors++; $display("FAIL conv_zero got %h want 000", dat0); end
    endtask

    task automatic test_command_random();
        logic [9:0] expv;
        int n;
        for (int f = 0; f < 4; f++) begin
            expv = 10'($urandom);
            val[0] = expv;
            n = 0;
            @(posedge clk); #1;
            while (n < 300 && valid[0] !== 1'b1) begin
                @(posedge clk); #1; n++;
            end
            checks++; if (dat0 !== expv) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", f, dat0, expv); end
            @(negedge clk); #1;
            checks++;
            if (last_dseen[0] !== cmd_pattern(1'b0)) begin
                errors++; $display("FAIL cmd_bits_ch0[%0d] got %h want %h", f, last_dseen[0], cmd_pattern(1'b0));
            end
            checks++; if (last_rc[0] !== 16) begin errors++; $display("FAIL rand_rises[%0d] got %0d want 16", f, last_rc[0]); end
        end
        checks++; if (stray[0] !== 0) begin errors++; $display("FAIL stray_sck got %0d want 0", stray[0]); end
    endtask

    task automatic test_abort();
        int k, pulses;
        logic [9:0] expv;
        k = 0;
        while (k < 400 && !(cs[0] === 1'b0 && sck[0] === 1'b1 && rc[0] == 7)) begin
            @(posedge clk); #1; k++;
        end
        rstn[0] = 1'b0;
        #1;
        checks++; if (cs[0] !== 1'b1) begin errors++; $display("FAIL abort_cs got %b want 1", cs[0]); end
        checks++; if (dat0 !== 10'd512) begin errors++; $display("FAIL abort_data got %0d want 512", dat0); end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid[0] === 1'b1) pulses++;
        end
        expv = 10'($urandom);
        val[0] = expv;
        rstn[0] = 1'b1;
        k = 0;
        while (k < 400 && valid[0] !== 1'b1) begin
            @(posedge clk); #1; k++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_valid got %0d pulses want 0", pulses); end
        checks++; if (k !== SD0 - 1 + LAT) begin errors++; $display("FAIL abort_refresh_time got %0d want %0d", k, SD0 - 1 + LAT); end
        checks++; if (dat0 !== expv) begin errors++; $display("FAIL abort_refresh_data got %h want %h", dat0, expv); end
    endtask

    task automatic test_extremes();
        int n, held_bad;
        val[0] = 10'h3FF;
        n = 0;
        @(posedge clk); #1;
        while (n < 300 && valid[0] !== 1'b1) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (dat0 !== 10'd1023) begin errors++; $display("FAIL extreme_max got %0d want 1023", dat0); end
        val[0] = 10'h001;
        n = 0; held_bad = 0;
        @(posedge clk); #1;
        while (n < 300 && valid[0] !== 1'b1) begin
            if (dat0 !== 10'd1023) held_bad++;
            @(posedge clk); #1; n++;
        end
        checks++; if (held_bad !== 0) begin errors++; $display("FAIL extreme_hold got %0d changes want 0", held_bad); end
        checks++; if (dat0 !== 10'd1) begin errors++; $display("FAIL extreme_min got %0d want 1", dat0); end
    endtask

    task automatic test_overrun();
        int falls [$], valids [$], exp_falls [$], exp_valids [$];
        int ovr_edge, ovr_drop, exp_ovr, idle_at, bad_data;
        logic prev_cs;
        logic [9:0] expv;
        // Expected frames: a tick is accepted only once the previous frame is back in IDLE.
        idle_at = 0; exp_ovr = -1;
        for (int t = SD1 - 1; t < 400; t += SD1) begin
            if (t >= idle_at) begin
                exp_falls.push_back(t + 1);
                if (t + LAT <= 400) exp_valids.push_back(t + LAT);
                idle_at = t + LAT + 1;
            end else if (exp_ovr < 0) begin
                exp_ovr = t + 1;
            end
        end
        expv = 10'($urandom);
        val[1] = expv;
        @(negedge clk);
        rstn[1] = 1'b1;
        prev_cs = 1'b1; ovr_edge = -1; ovr_drop = 0; bad_data = 0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (prev_cs === 1'b1 && cs[1] === 1'b0) falls.push_back(n);
            if (valid[1] === 1'b1) begin
                valids.push_back(n);
                if (dat1 !== expv) bad_data++;
            end
            if (ovr[1] === 1'b1 && ovr_edge < 0) ovr_edge = n;
            if (ovr_edge >= 0 && ovr[1] !== 1'b1) ovr_drop++;
            prev_cs = cs[1];
        end
        checks++; if (falls.size() !== exp_falls.size()) begin errors++; $display("FAIL ovr_frame_count got %0d want %0d", falls.size(), exp_falls.size()); end
        for (int i = 0; i < exp_falls.size() && i < falls.size(); i++) begin
            checks++; if (falls[i] !== exp_falls[i]) begin errors++; $display("FAIL ovr_fall[%0d] got %0d want %0d", i, falls[i], exp_falls[i]); end
        end
        checks++; if (valids.size() !== exp_valids.size()) begin errors++; $display("FAIL ovr_valid_count got %0d want %0d", valids.size(), exp_valids.size()); end
        for (int i = 0; i < exp_valids.size() && i < valids.size(); i++) begin
            checks++; if (valids[i] !== exp_valids[i]) begin errors++; $display("FAIL ovr_valid[%0d] got %0d want %0d", i, valids[i], exp_valids[i]); end
        end
        checks++; if (ovr_edge !== exp_ovr) begin errors++; $display("FAIL ovr_set_cycle got %0d want %0d", ovr_edge, exp_ovr); end
        checks++; if (ovr_drop !== 0) begin errors++; $display("FAIL ovr_sticky got %0d clears want 0", ovr_drop); end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL ovr_data got %0d bad want 0", bad_data); end
        checks++;
        if (last_dseen[1] !== cmd_pattern(1'b1)) begin
            errors++; $display("FAIL cmd_bits_ch1 got %h want %h", last_dseen[1], cmd_pattern(1'b1));
        end
        checks++; if (stray[1] !== 0) begin errors++; $display("FAIL stray_sck_ch1 got %0d want 0", stray[1]); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 2'b00;
        dout = 2'b00;
        val[0] = '0; val[1] = '0;
        for (int g = 0; g < 2; g++) begin
            rc[g] = 0; fc[g] = 0; lowcyc[g] = 0; stray[g] = 0;
            last_rc[g] = 0; last_low[g] = 0; dseen[g] = '0; last_dseen[g] = '0;
            prev_sck[g] = 1'b0; was_low[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        test_reset();
        test_conversion();
        test_command_random();
        test_abort();
        test_extremes();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
